// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: controller state encoding, forwarding-select codes, the per-stage
//          latch control bundle and its canonical values.
// Ports:   none (package).
package pipe_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // One stg_ena / stg_x pair per pipeline latch (PC has no bubble input).
  typedef struct packed {
    logic pc_ena;
    logic ifid_ena;
    logic idex_ena;
    logic exmem_ena;
    logic memwb_ena;
    logic ifid_x;
    logic idex_x;
    logic exmem_x;
    logic memwb_x;
  } stg_ctl_t;

  // Whole pipe frozen: nothing loads, nothing is cleared.
  localparam stg_ctl_t CTL_HOLD    = 9'b00000_0000;
  // Normal advance of every stage.
  localparam stg_ctl_t CTL_ADVANCE = 9'b11111_0000;
  // Taken branch: everything advances, the two younger latches are squashed.
  localparam stg_ctl_t CTL_FLUSH   = 9'b11111_1100;
  // Load-use: PC and IF/ID hold, a bubble is loaded into ID/EX, older stages drain.
  localparam stg_ctl_t CTL_BUBBLE  = 9'b00111_0100;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
// Purpose: groups run/step control, the hazard-relevant latch fields, the
//          memory handshake and all controller outputs.
// Modports: master = datapath side (drives hazard inputs, consumes controls),
//           slave  = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 16
);
  logic              run;
  logic              step;
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              ifid_use_rs1;
  logic              ifid_use_rs2;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_is_load;
  logic              idex_save_to_reg;
  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_save_to_reg;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_save_to_reg;
  logic              branch_taken;
  logic              mem_req;
  logic              mem_ready;

  logic              pc_ena;
  logic              ifid_ena;
  logic              idex_ena;
  logic              exmem_ena;
  logic              memwb_ena;
  logic              ifid_x;
  logic              idex_x;
  logic              exmem_x;
  logic              memwb_x;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              halted;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output run, step, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           idex_rd, idex_is_load, idex_save_to_reg, idex_rs1, idex_rs2,
           exmem_rd, exmem_save_to_reg, memwb_rd, memwb_save_to_reg,
           branch_taken, mem_req, mem_ready,
    input  pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
           ifid_x, idex_x, exmem_x, memwb_x, fwd_a, fwd_b,
           halted, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  run, step, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           idex_rd, idex_is_load, idex_save_to_reg, idex_rs1, idex_rs2,
           exmem_rd, exmem_save_to_reg, memwb_rd, memwb_save_to_reg,
           branch_taken, mem_req, mem_ready,
    output pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
           ifid_x, idex_x, exmem_x, memwb_x, fwd_a, fwd_b,
           halted, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// rtl/pipe_hazard_ctrl_fwd_unit.sv - EX operand forwarding select for one operand
// Purpose: picks the youngest in-flight producer of src_i; EX/MEM wins over MEM/WB.
// Ports:   src_i            EX operand source register
//          exmem_rd_i/_save_to_reg_i, memwb_rd_i/_save_to_reg_i  producer fields
//          sel_o            FWD_REG / FWD_EXMEM / FWD_MEMWB
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_save_to_reg_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_save_to_reg_i,
  output logic [1:0]        sel_o
);

  // x0 is hard-wired zero, so a write to it is never a producer.
  always_comb begin
    sel_o = FWD_REG;
    if (exmem_save_to_reg_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_save_to_reg_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stage enable / bubble controller for the 5-stage core
// Purpose: resolves load-use stalls, taken-branch flushes and multi-cycle
//          memory freezes; run/step control; forwarding selects; saturating
//          stall/flush counters; sticky memory-timeout flag.
// Ports:   stg_clk  pipeline clock
//          reset    asynchronous active-high reset
//          ctrl     pipe_hazard_ctrl_if.slave (hazard inputs, latch controls,
//                   fwd_a/fwd_b, halted, mem_err, stall_cnt, flush_cnt)
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              stg_clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave ctrl
);

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              step_entry_q, step_entry_d;  // MEM_WAIT was entered from a single step
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  stg_ctl_t          ctl;
  logic              advance;     // apply branch / load-use / normal rules this cycle
  logic              stall_inc;
  logic              flush_inc;
  logic              freeze_req;
  logic              load_use;

  assign freeze_req = ctrl.mem_req && !ctrl.mem_ready;

  assign load_use = ctrl.idex_is_load && ctrl.idex_save_to_reg && (ctrl.idex_rd != '0) &&
                    ((ctrl.ifid_use_rs1 && (ctrl.ifid_rs1 == ctrl.idex_rd)) ||
                     (ctrl.ifid_use_rs2 && (ctrl.ifid_rs2 == ctrl.idex_rd)));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    step_entry_d = step_entry_q;
    mem_err_d    = mem_err_q;
    ctl          = CTL_HOLD;
    advance      = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl.run) begin
          state_d = RUN;
        end else if (ctrl.step) begin
          // A step is a RUN cycle that leaves the controller halted.
          if (freeze_req) begin
            state_d      = MEM_WAIT;
            wait_d       = WAIT_W'(1);
            step_entry_d = 1'b1;
            stall_inc    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end

      RUN: begin
        if (freeze_req) begin
          state_d      = MEM_WAIT;
          wait_d       = WAIT_W'(1);
          step_entry_d = 1'b0;
          stall_inc    = 1'b1;
        end else begin
          advance = 1'b1;
          if (!ctrl.run) begin
            state_d = IDLE;
          end
        end
      end

      MEM_WAIT: begin
        if (!ctrl.mem_ready) begin
          stall_inc = 1'b1;
          if (wait_q >= WAIT_MAX) begin
            mem_err_d = 1'b1;
            state_d   = IDLE;
            wait_d    = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          // Completion cycle behaves like a normal RUN cycle minus the freeze check.
          advance = 1'b1;
          wait_d  = '0;
          state_d = step_entry_q ? IDLE : RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (ctrl.branch_taken) begin
        ctl       = CTL_FLUSH;
        flush_inc = 1'b1;
      end else if (load_use) begin
        ctl       = CTL_BUBBLE;
        stall_inc = 1'b1;
      end else begin
        ctl = CTL_ADVANCE;
      end
    end

    // A step held across reset must not leak enables while reset is asserted.
    if (reset) begin
      ctl = CTL_HOLD;
    end

    stall_d = (stall_inc && (stall_q != CNT_MAX)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush_inc && (flush_q != CNT_MAX)) ? flush_q + CNT_W'(1) : flush_q;
  end

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      step_entry_q <= 1'b0;
      mem_err_q    <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      step_entry_q <= step_entry_d;
      mem_err_q    <= mem_err_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i               (ctrl.idex_rs1),
    .exmem_rd_i          (ctrl.exmem_rd),
    .exmem_save_to_reg_i (ctrl.exmem_save_to_reg),
    .memwb_rd_i          (ctrl.memwb_rd),
    .memwb_save_to_reg_i (ctrl.memwb_save_to_reg),
    .sel_o               (ctrl.fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i               (ctrl.idex_rs2),
    .exmem_rd_i          (ctrl.exmem_rd),
    .exmem_save_to_reg_i (ctrl.exmem_save_to_reg),
    .memwb_rd_i          (ctrl.memwb_rd),
    .memwb_save_to_reg_i (ctrl.memwb_save_to_reg),
    .sel_o               (ctrl.fwd_b)
  );

  assign ctrl.pc_ena    = ctl.pc_ena;
  assign ctrl.ifid_ena  = ctl.ifid_ena;
  assign ctrl.idex_ena  = ctl.idex_ena;
  assign ctrl.exmem_ena = ctl.exmem_ena;
  assign ctrl.memwb_ena = ctl.memwb_ena;
  assign ctrl.ifid_x    = ctl.ifid_x;
  assign ctrl.idex_x    = ctl.idex_x;
  assign ctrl.exmem_x   = ctl.exmem_x;
  assign ctrl.memwb_x   = ctl.memwb_x;
  assign ctrl.halted    = (state_q == IDLE);
  assign ctrl.mem_err   = mem_err_q;
  assign ctrl.stall_cnt = stall_q;
  assign ctrl.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int AW   = 5;
  localparam int TMO  = 15;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic stg_clk = 1'b0;
  logic reset   = 1'b1;

  always #5 stg_clk = ~stg_clk;

  pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .stg_clk (stg_clk),
    .reset   (reset),
    .ctrl    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: "is the pipe free-running", "is a memory access pending".
  bit m_running, m_waiting, m_step_wait, m_err;
  int m_wait_len, m_stall, m_flush;

  logic [4:0] e_ena;
  logic [3:0] e_x;
  logic [1:0] e_fa, e_fb;
  logic       e_halt;

  logic [4:0] obs_ena;
  logic [3:0] obs_x;
  assign obs_ena = {bus.pc_ena, bus.ifid_ena, bus.idex_ena, bus.exmem_ena, bus.memwb_ena};
  assign obs_x   = {bus.ifid_x, bus.idex_x, bus.exmem_x, bus.memwb_x};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.run = 0; bus.step = 0;
    bus.ifid_rs1 = '0; bus.ifid_rs2 = '0; bus.ifid_use_rs1 = 0; bus.ifid_use_rs2 = 0;
    bus.idex_rd = '0; bus.idex_is_load = 0; bus.idex_save_to_reg = 0;
    bus.idex_rs1 = '0; bus.idex_rs2 = '0;
    bus.exmem_rd = '0; bus.exmem_save_to_reg = 0;
    bus.memwb_rd = '0; bus.memwb_save_to_reg = 0;
    bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  task automatic model_reset();
    m_running = 0; m_waiting = 0; m_step_wait = 0; m_err = 0;
    m_wait_len = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic bump_stall();
    if (m_stall < CMAX) m_stall++;
  endtask

  task automatic bump_flush();
    if (m_flush < CMAX) m_flush++;
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] src);
    if (bus.exmem_save_to_reg && bus.exmem_rd != 0 && bus.exmem_rd == src) return 2'b01;
    if (bus.memwb_save_to_reg && bus.memwb_rd != 0 && bus.memwb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  // Computes this cycle's expected controls and moves the model to the next cycle.
  task automatic model_eval();
    bit hazard, do_rules;
    hazard = bus.idex_is_load && bus.idex_save_to_reg && bus.idex_rd != 0 &&
             ((bus.ifid_use_rs1 && bus.ifid_rs1 == bus.idex_rd) ||
              (bus.ifid_use_rs2 && bus.ifid_rs2 == bus.idex_rd));
    e_halt   = !m_running && !m_waiting;
    e_ena    = 5'b00000;
    e_x      = 4'b0000;
    do_rules = 0;
    if (m_waiting) begin
      if (!bus.mem_ready) begin
        bump_stall();
        if (m_wait_len >= TMO) begin
          m_err = 1; m_waiting = 0; m_running = 0;
        end else begin
          m_wait_len++;
        end
      end else begin
        do_rules  = 1;
        m_waiting = 0;
        m_running = !m_step_wait;
      end
    end else if (m_running || (!bus.run && bus.step)) begin
      if (bus.mem_req && !bus.mem_ready) begin
        bump_stall();
        m_step_wait = !m_running;
        m_waiting   = 1;
        m_wait_len  = 1;
      end else begin
        do_rules = 1;
        if (!bus.run) m_running = 0;
      end
    end else if (bus.run) begin
      m_running = 1;
    end
    if (do_rules) begin
      if (bus.branch_taken) begin
        e_ena = 5'b11111; e_x = 4'b1100; bump_flush();
      end else if (hazard) begin
        e_ena = 5'b00111; e_x = 4'b0100; bump_stall();
      end else begin
        e_ena = 5'b11111;
      end
    end
    e_fa = fwd_ref(bus.idex_rs1);
    e_fb = fwd_ref(bus.idex_rs2);
  endtask

  // Inputs are already applied; sample at the falling edge, then clock once.
  task automatic tick(input string tag);
    @(negedge stg_clk);
    chk({tag, ":stall_cnt"}, 32'(bus.stall_cnt), m_stall);
    chk({tag, ":flush_cnt"}, 32'(bus.flush_cnt), m_flush);
    chk({tag, ":mem_err"}, 32'(bus.mem_err), 32'(m_err));
    model_eval();
    chk({tag, ":ena"}, 32'(obs_ena), 32'(e_ena));
    chk({tag, ":x"}, 32'(obs_x), 32'(e_x));
    chk({tag, ":fwd_a"}, 32'(bus.fwd_a), 32'(e_fa));
    chk({tag, ":fwd_b"}, 32'(bus.fwd_b), 32'(e_fb));
    chk({tag, ":halted"}, 32'(bus.halted), 32'(e_halt));
    @(posedge stg_clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    bus.step = 1;  // a step held during reset must still produce no enables
    reset = 1;
    #1;
    chk("rst:ena", 32'(obs_ena), 0);
    chk("rst:x", 32'(obs_x), 0);
    chk("rst:halted", 32'(bus.halted), 1);
    chk("rst:stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst:flush_cnt", 32'(bus.flush_cnt), 0);
    chk("rst:mem_err", 32'(bus.mem_err), 0);
    @(posedge stg_clk);
    #1;
    bus.step = 0;
    reset = 0;
    model_reset();
  endtask

  task automatic set_load_use(input logic [AW-1:0] rd);
    bus.idex_is_load = 1; bus.idex_save_to_reg = 1; bus.idex_rd = rd;
    bus.ifid_rs1 = rd; bus.ifid_use_rs1 = 1;
  endtask

  initial begin
    clear_inputs();
    model_reset();

    // Forwarding selects are combinational and valid while reset is held.
    reset = 1;
    bus.exmem_rd = 5'd7; bus.memwb_rd = 5'd7; bus.idex_rs1 = 5'd7;
    bus.exmem_save_to_reg = 1; bus.memwb_save_to_reg = 1;
    #1 chk("fwd_both", 32'(bus.fwd_a), 1);
    bus.exmem_save_to_reg = 0;
    #1 chk("fwd_memwb", 32'(bus.fwd_a), 2);
    bus.idex_rs1 = 5'd0;
    #1 chk("fwd_rs0", 32'(bus.fwd_a), 0);
    bus.idex_rs2 = 5'd7;
    #1 chk("fwd_b_memwb", 32'(bus.fwd_b), 2);

    // Load-use stall, then the same with rd = x0.
    do_reset();
    bus.run = 1;
    tick("start");
    set_load_use(5'd5);
    tick("load_use");
    chk("load_use_stall", 32'(bus.stall_cnt), 1);
    set_load_use(5'd0);
    tick("load_use_rd0");
    chk("rd0_no_stall", 32'(bus.stall_cnt), 1);

    // Branch beats a simultaneous load-use hazard.
    set_load_use(5'd5);
    bus.branch_taken = 1;
    tick("branch");
    chk("branch_flush", 32'(bus.flush_cnt), 1);
    chk("branch_stall", 32'(bus.stall_cnt), 1);
    clear_inputs();
    bus.run = 1;
    tick("after_branch");

    // Memory freeze: four freeze cycles (entry included), then completion.
    do_reset();
    bus.run = 1;
    tick("mw_start");
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (4) tick("mw_freeze");
    bus.mem_ready = 1;
    tick("mw_done");
    chk("mw_stall", 32'(bus.stall_cnt), 4);
    chk("mw_running", 32'(bus.halted), 0);
    bus.mem_req = 0;
    tick("mw_after");

    // Timeout: entry cycle plus MEM_TIMEOUT wait cycles raises the sticky error.
    do_reset();
    bus.run = 1;
    tick("tmo_start");
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (TMO) tick("tmo_wait");
    chk("tmo_not_yet", 32'(bus.mem_err), 0);
    tick("tmo_last");
    chk("tmo_err", 32'(bus.mem_err), 1);
    chk("tmo_halted", 32'(bus.halted), 1);
    bus.mem_req = 0;
    repeat (3) tick("tmo_after");
    chk("tmo_sticky", 32'(bus.mem_err), 1);

    // Single step while halted, then a step that hits a memory freeze.
    do_reset();
    tick("halt");
    bus.step = 1;
    tick("step");
    bus.step = 0;
    tick("step_after");
    chk("step_halted", 32'(bus.halted), 1);
    bus.step = 1; bus.mem_req = 1; bus.mem_ready = 0;
    tick("step_freeze");
    bus.step = 0;
    repeat (2) tick("step_wait");
    bus.mem_ready = 1;
    tick("step_done");
    bus.mem_req = 0;
    tick("step_back_idle");
    chk("step_idle", 32'(bus.halted), 1);

    // Reset asserted in the middle of MEM_WAIT.
    bus.run = 1;
    tick("rmw_start");
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (2) tick("rmw_freeze");
    bus.mem_ready = 1;
    #2 reset = 1;
    #1;
    chk("rmw_ena", 32'(obs_ena), 0);
    chk("rmw_halted", 32'(bus.halted), 1);
    chk("rmw_stall", 32'(bus.stall_cnt), 0);
    @(posedge stg_clk);
    #1 reset = 0;
    model_reset();
    clear_inputs();

    // Randomized traffic against the model; long enough to saturate both counters.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.run               = ($urandom_range(0, 9) != 0);
      bus.step              = ($urandom_range(0, 1) != 0);
      bus.ifid_rs1          = AW'($urandom_range(0, 3));
      bus.ifid_rs2          = AW'($urandom_range(0, 3));
      bus.ifid_use_rs1      = ($urandom_range(0, 1) != 0);
      bus.ifid_use_rs2      = ($urandom_range(0, 1) != 0);
      bus.idex_rd           = AW'($urandom_range(0, 3));
      bus.idex_is_load      = ($urandom_range(0, 1) != 0);
      bus.idex_save_to_reg  = ($urandom_range(0, 3) != 0);
      bus.idex_rs1          = AW'($urandom_range(0, 3));
      bus.idex_rs2          = AW'($urandom_range(0, 3));
      bus.exmem_rd          = AW'($urandom_range(0, 3));
      bus.exmem_save_to_reg = ($urandom_range(0, 1) != 0);
      bus.memwb_rd          = AW'($urandom_range(0, 3));
      bus.memwb_save_to_reg = ($urandom_range(0, 1) != 0);
      bus.branch_taken      = ($urandom_range(0, 4) == 0);
      bus.mem_req           = ($urandom_range(0, 3) == 0);
      bus.mem_ready         = ($urandom_range(0, 2) != 0);
      tick("rand");
    end
    chk("rand_stall_sat", 32'(bus.stall_cnt), CMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
